// File: rtl/online_ccm_seq.sv
// Serial MSD-first online multiplier by C = (+/-2^S1) + (+/-2^S2), signed-digit in and out.
// Latency: out_valid rises NOUT+2 cycles after the accept edge; one job in flight at a time.
// Backpressure: in_ready low while busy; y/out_valid held in DONE until out_ready.
module online_ccm_seq #(
   parameter int STAGE = 4,
   parameter int SMAX  = 4,
   parameter int SW    = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [2*STAGE-1:0]                x,
   input  logic [SW-1:0]                     cfg_s1,
   input  logic [SW-1:0]                     cfg_s2,
   input  logic                              cfg_neg1,
   input  logic                              cfg_neg2,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [2*(STAGE+SMAX+1)-1:0]       y
);

   localparam int NOUT = STAGE + SMAX + 1;
   localparam int CW   = $clog2(NOUT + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(NOUT + 1);
   localparam logic signed [2:0] P1 = 3'sd1;
   localparam logic signed [2:0] P2 = 3'sd2;
   localparam logic signed [2:0] M1 = -3'sd1;
   localparam logic signed [2:0] M2 = -3'sd2;
   localparam logic signed [2:0] Z0 = 3'sd0;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2*STAGE-1:0] x_r;
   logic [SW-1:0]     s1_r, s2_r;
   logic              neg1_r, neg2_r;
   // g_r: level-1 remainder of the previous (heavier) weight; w_r: level-2 remainder
   logic signed [2:0] g_r, w_r;
   // owe: +/-1 pending at the weight just above the current output digit
   logic signed [2:0] owe;

   logic [1:0]        a_dig, b_dig, y_dig;
   logic signed [2:0] sum, hval, gval, vsum, tval, wval, zval, emit, owe_nx;
   int                kw;

   function automatic logic signed [2:0] dig_val(input logic [1:0] d);
      return $signed({2'b00, d[1]}) - $signed({2'b00, d[0]});
   endfunction

   function automatic logic [1:0] dig_enc(input logic signed [2:0] v);
      if (v == P1)      return 2'b10;
      else if (v == M1) return 2'b01;
      else              return 2'b00;
   endfunction

   // Operand digits at the current weight, then two-level signed-digit addition plus top-digit folding
   always_comb begin
      kw    = NOUT - 1 - int'(cnt);
      a_dig = 2'b00;
      b_dig = 2'b00;
      if (cnt < CW'(NOUT)) begin
         for (int i = 0; i < STAGE; i++) begin
            if (i + int'(s1_r) == kw) a_dig = x_r[2*i +: 2];
            if (i + int'(s2_r) == kw) b_dig = x_r[2*i +: 2];
         end
      end
      if (neg1_r) a_dig = {a_dig[0], a_dig[1]};
      if (neg2_r) b_dig = {b_dig[0], b_dig[1]};

      // level 1: a+b = 2h + g, h in {-1,0,1}, g in {-1,0}
      sum  = dig_val(a_dig) + dig_val(b_dig);
      hval = Z0;
      gval = Z0;
      case (sum)
         P2:      hval = P1;
         P1:      begin hval = P1; gval = M1; end
         M1:      gval = M1;
         M2:      hval = M1;
         default: ;
      endcase

      // level 2 on the previous weight: g + h = 2t + w, t in {-1,0}, w in {0,1}
      vsum = g_r + hval;
      tval = Z0;
      wval = Z0;
      case (vsum)
         M2:      tval = M1;
         M1:      begin tval = M1; wval = P1; end
         P1:      wval = P1;
         default: ;
      endcase
      zval = w_r + tval;

      // The digit at weight NOUT can be nonzero even though the value fits; it is carried
      // down as 'owe' and absorbed by the first nonzero digit below, which must cancel it.
      emit   = zval;
      owe_nx = Z0;
      if (cnt < CW'(2)) begin
         owe_nx = zval;
      end else if (owe != Z0) begin
         emit   = owe;
         owe_nx = (zval != Z0) ? Z0 : owe;
      end
      y_dig = dig_enc(emit);
   end

   // Handshake FSM, operand capture and serial accumulation of y (MSD first)
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
         x_r       <= '0;
         s1_r      <= '0;
         s2_r      <= '0;
         neg1_r    <= 1'b0;
         neg2_r    <= 1'b0;
         g_r       <= Z0;
         w_r       <= Z0;
         owe       <= Z0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  x_r      <= x;
                  s1_r     <= cfg_s1;
                  s2_r     <= cfg_s2;
                  neg1_r   <= cfg_neg1;
                  neg2_r   <= cfg_neg2;
                  cnt      <= '0;
                  g_r      <= Z0;
                  w_r      <= Z0;
                  owe      <= Z0;
                  y        <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               g_r <= gval;
               w_r <= wval;
               owe <= owe_nx;
               y   <= {y[2*NOUT-3:0], y_dig};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_online_ccm_seq.sv
// Directed bench for online_ccm_seq: value of y, latency, handshake and reset abort.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// The consumer stalls in DONE where a vector asks for it.
module tb_online_ccm_seq;

   localparam int STAGE = 4;
   localparam int SMAX  = 4;
   localparam int SW    = 3;
   localparam int NOUT  = STAGE + SMAX + 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [2*STAGE-1:0]   x = '0;
   logic [SW-1:0]        cfg_s1 = '0;
   logic [SW-1:0]        cfg_s2 = '0;
   logic                 cfg_neg1 = 1'b0;
   logic                 cfg_neg2 = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [2*NOUT-1:0]    y;

   int total = 0;
   int bad   = 0;

   online_ccm_seq #(.STAGE(STAGE), .SMAX(SMAX), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .cfg_s1    (cfg_s1),
      .cfg_s2    (cfg_s2),
      .cfg_neg1  (cfg_neg1),
      .cfg_neg2  (cfg_neg2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sd_val(input logic [2*NOUT-1:0] v);
      int acc;
      acc = 0;
      for (int i = 0; i < NOUT; i++)
         acc += (int'(v[2*i+1]) - int'(v[2*i])) * (1 << i);
      return acc;
   endfunction

   function automatic logic [2*STAGE-1:0] mk_x(input logic [STAGE-1:0] p, input logic [STAGE-1:0] n);
      logic [2*STAGE-1:0] r;
      for (int i = 0; i < STAGE; i++) begin
         r[2*i+1] = p[i];
         r[2*i]   = n[i];
      end
      return r;
   endfunction

   task automatic run_txn(input string tag, input logic [STAGE-1:0] p, input logic [STAGE-1:0] n,
                          input int s1, input int s2, input logic n1, input logic n2,
                          input int exp_val, input bit check_val, input int hold);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk({tag, " in_ready before accept"}, int'(in_ready), 1);
      x        = mk_x(p, n);
      cfg_s1   = SW'(s1);
      cfg_s2   = SW'(s2);
      cfg_neg1 = n1;
      cfg_neg2 = n2;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // scramble inputs after the accept edge; they must not matter
      x        = mk_x(4'b1010, 4'b0101);
      cfg_s1   = SW'(1);
      cfg_neg1 = ~n1;
      chk({tag, " in_ready after accept"}, int'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, NOUT + 2);
      if (check_val) chk({tag, " value"}, sd_val(y), exp_val);
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin
            in_valid = 1'b1;
            x        = mk_x(4'b0111, 4'b0000);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk({tag, " hold out_valid"}, int'(out_valid), 1);
         chk({tag, " hold in_ready"}, int'(in_ready), 0);
         if (check_val) chk({tag, " hold value"}, sd_val(y), exp_val);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid drops"}, int'(out_valid), 0);
      chk({tag, " in_ready returns"}, int'(in_ready), 1);
   endtask

   initial begin
      bit seen;

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", int'(in_ready), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset y", int'(y), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready after reset", int'(in_ready), 1);

      // baseline C=24 with 5-cycle stall and an ignored in_valid pulse
      run_txn("x5_c24_hold", 4'b0101, 4'b0000, 4, 3, 1'b0, 1'b0, 120, 1'b1, 5);
      // subtraction, negative input: C=16-1=15, x=-15
      run_txn("xm15_c15", 4'b0000, 4'b1111, 4, 0, 1'b0, 1'b1, -225, 1'b1, 0);
      // redundant digits including (1,1): value 5
      run_txn("redund_c24", 4'b1111, 4'b1010, 4, 3, 1'b0, 1'b0, 120, 1'b1, 0);
      // S1=S2 with cancellation: C=0
      run_txn("x9_c0", 4'b1001, 4'b0000, 2, 2, 1'b0, 1'b1, 0, 1'b1, 0);
      // maximum magnitudes
      run_txn("x15_c32", 4'b1111, 4'b0000, 4, 4, 1'b0, 1'b0, 480, 1'b1, 0);
      run_txn("x15_cm32", 4'b1111, 4'b0000, 4, 4, 1'b1, 1'b1, -480, 1'b1, 0);
      // back-to-back small coefficients: C=-1+2=1 and C=2-1=1
      run_txn("xm1_c1", 4'b0000, 4'b0001, 0, 1, 1'b1, 1'b0, -1, 1'b1, 0);
      run_txn("x6_c1", 4'b0110, 4'b0000, 1, 0, 1'b0, 1'b1, 6, 1'b1, 0);
      // illegal shifts: value undefined, but the job must still complete
      run_txn("illegal_shift", 4'b0101, 4'b0000, 7, 5, 1'b0, 1'b0, 0, 1'b0, 0);

      // reset four edges into a job aborts it
      x        = mk_x(4'b0101, 4'b0000);
      cfg_s1   = SW'(4);
      cfg_s2   = SW'(3);
      cfg_neg1 = 1'b0;
      cfg_neg2 = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort in_ready during reset", int'(in_ready), 0);
      chk("abort out_valid during reset", int'(out_valid), 0);
      @(posedge clk); #1;
      chk("abort in_ready after release", int'(in_ready), 1);
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort no out_valid", int'(seen), 0);

      run_txn("x3_c24_after_abort", 4'b0011, 4'b0000, 4, 3, 1'b0, 1'b0, 72, 1'b1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
